// File: rtl/bmult_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : bmult_prod_accum
// Purpose  : Group accumulator for the 6x6 multiplier's product stream.
//            It produces one registered sum, count and overflow result per group.
// Revision : 1.0
// ============================================================================
module bmult_prod_accum #(
  parameter int P_WIDTH   = 12,
  parameter int ACC_WIDTH = 20,
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [P_WIDTH-1:0]   in_p,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  localparam int C_SUM_W = ACC_WIDTH + 1;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic [ACC_WIDTH-1:0] r_out_sum;
  logic [CNT_WIDTH-1:0] r_out_count;
  logic                 r_out_ovf;

  logic                 w_accept;
  logic [C_SUM_W-1:0]   w_sum;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_ovf_nxt;

  // Handshake flags depend on the state only, so out_ready cannot reach in_ready.
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign w_accept  = in_valid && in_ready;

  // The extra top bit of w_sum holds the carry out of the accumulator.
  assign w_sum     = {1'b0, r_acc} + C_SUM_W'(in_p);
  assign w_ovf_nxt = r_ovf | w_sum[ACC_WIDTH];
  assign w_cnt_nxt = (r_cnt == {CNT_WIDTH{1'b1}}) ? r_cnt : r_cnt + CNT_WIDTH'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_accept && in_last) w_state_nxt = HOLD;
      HOLD:    if (out_ready)           w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (in_last) begin
          r_out_sum   <= w_sum[ACC_WIDTH-1:0];
          r_out_count <= w_cnt_nxt;
          r_out_ovf   <= w_ovf_nxt;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc <= w_sum[ACC_WIDTH-1:0];
          r_cnt <= w_cnt_nxt;
          r_ovf <= w_ovf_nxt;
        end
      end
    end
  end

  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
